bus_responder: RTL and testbench



---
 rtl/bus_responder.sv | 176 +++++++++++++++++
 tb/tb_bus_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_responder
// Purpose  : Memory-mapped register window answering CPU bus cycles with
//            programmable wait states. Optional macro
//            BUS_RESPONDER_ACCESS_CNT_EN turns word 0 into a reply counter.
// Revision : 1.0 - initial release
// ============================================================================
module bus_responder #(
    parameter logic [15:0] BASE   = 16'o177700,
    parameter int          NWORDS = 8,
    parameter int          WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        sync,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    input  logic [15:0] dba,
    input  logic [15:0] dbo,
    output logic [15:0] dbi,
    output logic        rply,
    output logic        hit
);

    localparam int          c_IDX_W    = $clog2(NWORDS);
    localparam logic [14:0] c_BASE_W   = BASE[15:1];
    localparam logic [14:0] c_NWORDS_W = 15'(NWORDS);
    localparam logic [3:0]  c_WAIT     = 4'(WAIT);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ADDR  = 2'd1;
    localparam logic [1:0] c_S_WAITS = 2'd2;
    localparam logic [1:0] c_S_REPLY = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_sync_d;
    logic [c_IDX_W:0]   r_adr;
    logic               r_hit;
    logic [3:0]         r_cnt;
    logic               r_wr;
    logic               r_rply;
    logic [15:0]        r_dbi;
    logic [15:0]        r_mem [NWORDS];

    logic [c_IDX_W-1:0] w_idx;
    logic [14:0]        w_off;
    logic               w_hit_dba;
    logic               w_strobe;
    logic [15:0]        w_old;
    logic [15:0]        w_wdata;
    logic [15:0]        w_rdata;

`ifdef BUS_RESPONDER_ACCESS_CNT_EN
    logic [15:0]        r_acc_cnt;
`endif

    assign w_idx     = r_adr[c_IDX_W:1];
    assign w_off     = dba[15:1] - c_BASE_W;
    assign w_hit_dba = (w_off < c_NWORDS_W);
    // Once a cycle is committed, only the chosen strobe keeps it alive.
    assign w_strobe  = r_wr ? dout : din;
    assign w_old     = r_mem[w_idx];

    always_comb begin
        w_wdata = dbo;
        if (wtbt) begin
            if (r_adr[0]) w_wdata = {dbo[15:8], w_old[7:0]};
            else          w_wdata = {w_old[15:8], dbo[7:0]};
        end
    end

`ifdef BUS_RESPONDER_ACCESS_CNT_EN
    assign w_rdata = (w_idx == '0) ? r_acc_cnt : w_old;
`else
    assign w_rdata = w_old;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (sync && !r_sync_d) w_state_nxt = c_S_ADDR;
            c_S_ADDR: begin
                if (!sync)                      w_state_nxt = c_S_IDLE;
                else if (r_hit && (din || dout)) w_state_nxt = c_S_WAITS;
            end
            c_S_WAITS: begin
                if (!sync)            w_state_nxt = c_S_IDLE;
                else if (!w_strobe)   w_state_nxt = c_S_ADDR;
                else if (r_cnt == '0) w_state_nxt = c_S_REPLY;
            end
            default: begin
                if (!sync)          w_state_nxt = c_S_IDLE;
                else if (!w_strobe) w_state_nxt = c_S_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)   r_state <= c_S_IDLE;
        else if (ce) r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_d <= 1'b0;
            r_adr    <= '0;
            r_hit    <= 1'b0;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_rply   <= 1'b0;
            r_dbi    <= '0;
            for (int i = 0; i < NWORDS; i++) r_mem[i] <= '0;
`ifdef BUS_RESPONDER_ACCESS_CNT_EN
            r_acc_cnt <= '0;
`endif
        end else if (ce) begin
            r_sync_d <= sync;
            if (w_state_nxt == c_S_IDLE) r_hit <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_state_nxt == c_S_ADDR) begin
                        r_adr <= dba[c_IDX_W:0];
                        r_hit <= w_hit_dba;
                    end
                end
                c_S_ADDR: begin
                    if (w_state_nxt == c_S_WAITS) begin
                        r_cnt <= c_WAIT;
                        r_wr  <= !din;
                    end
                end
                c_S_WAITS: begin
                    if (w_state_nxt == c_S_WAITS) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (w_state_nxt == c_S_REPLY) begin
                        r_rply <= 1'b1;
                        if (r_wr) begin
`ifdef BUS_RESPONDER_ACCESS_CNT_EN
                            // A write to the counter word clears it and is not counted.
                            if (w_idx == '0) begin
                                r_acc_cnt <= '0;
                            end else begin
                                r_mem[w_idx] <= w_wdata;
                                r_acc_cnt    <= r_acc_cnt + 16'd1;
                            end
`else
                            r_mem[w_idx] <= w_wdata;
`endif
                        end else begin
                            r_dbi <= w_rdata;
`ifdef BUS_RESPONDER_ACCESS_CNT_EN
                            r_acc_cnt <= r_acc_cnt + 16'd1;
`endif
                        end
                    end
                end
                default: begin
                    if (w_state_nxt != c_S_REPLY) begin
                        r_rply <= 1'b0;
                        r_dbi  <= '0;
                    end
                end
            endcase
        end
    end

    assign dbi  = r_dbi;
    assign rply = r_rply;
    assign hit  = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_responder
// Purpose  : Directed self-checking bench for bus_responder (BASE=177700,
//            NWORDS=8, WAIT=2); covers BUS_RESPONDER_ACCESS_CNT_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

    localparam int c_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset, ce, sync, din, dout, wtbt;
    logic [15:0] dba, dbo, dbi;
    logic        rply, hit;

    int n_checks = 0;
    int n_pass   = 0;

    bus_responder #(.BASE(16'o177700), .NWORDS(8), .WAIT(c_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .sync  (sync),
        .din   (din),
        .dout  (dout),
        .wtbt  (wtbt),
        .dba   (dba),
        .dbo   (dbo),
        .dbi   (dbi),
        .rply  (rply),
        .hit   (hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %06o expected %06o", tag, obs, exp);
    endtask

    task automatic bus_start(input logic [15:0] a, input logic exp_hit);
        dba  = a;
        sync = 1'b1;
        tick();
        chk("hit_latch", {15'd0, hit}, {15'd0, exp_hit});
    endtask

    // One strobe phase inside an already-open sync; checks the reply timing.
    task automatic bus_phase(input logic wr, input logic bt, input logic [15:0] d,
                             output logic [15:0] rd);
        wtbt = bt;
        dbo  = d;
        if (wr) dout = 1'b1;
        else    din  = 1'b1;
        tick();
        repeat (c_WAIT) tick();
        chk("rply_early", {15'd0, rply}, 16'd0);
        tick();
        chk("rply_on", {15'd0, rply}, 16'd1);
        rd = dbi;
        tick();
        chk("rply_hold", {15'd0, rply}, 16'd1);
        dout = 1'b0;
        din  = 1'b0;
        wtbt = 1'b0;
        tick();
        chk("rply_off", {15'd0, rply}, 16'd0);
        chk("dbi_idle", dbi, 16'd0);
    endtask

    task automatic bus_end();
        sync = 1'b0;
        tick();
        chk("hit_clear", {15'd0, hit}, 16'd0);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic bt, input logic [15:0] d);
        logic [15:0] rd;
        bus_start(a, 1'b1);
        bus_phase(1'b1, bt, d, rd);
        bus_end();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] rd);
        bus_start(a, 1'b1);
        bus_phase(1'b0, 1'b0, 16'd0, rd);
        bus_end();
    endtask

    initial begin
        logic [15:0] rd;
        int          seen;

        reset = 1'b1; ce = 1'b1; sync = 1'b0; din = 1'b0; dout = 1'b0;
        wtbt  = 1'b0; dba = '0;  dbo = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_rply", {15'd0, rply}, 16'd0);
        chk("reset_dbi", dbi, 16'd0);
        chk("reset_hit", {15'd0, hit}, 16'd0);

        // Word write/read
        bus_write(16'o177704, 1'b0, 16'o123456);
        bus_read(16'o177704, rd);
        chk("word_read", rd, 16'o123456);

        // Byte lanes
        bus_write(16'o177702, 1'b0, 16'o000000);
        bus_write(16'o177703, 1'b1, 16'o052400);
        bus_read(16'o177702, rd);
        chk("byte_hi", rd, 16'o052400);
        bus_write(16'o177702, 1'b1, 16'o000377);
        bus_read(16'o177702, rd);
        chk("byte_lo", rd, 16'o052777);

        // Miss
        bus_start(16'o177600, 1'b0);
        din  = 1'b1;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rply) seen++;
        end
        chk("miss_rply", 16'(seen), 16'd0);
        chk("miss_dbi", dbi, 16'd0);
        chk("miss_hit", {15'd0, hit}, 16'd0);
        din = 1'b0;
        bus_end();

        // DATIO: read then write under one sync
        bus_write(16'o177706, 1'b0, 16'o000111);
        bus_start(16'o177706, 1'b1);
        bus_phase(1'b0, 1'b0, 16'd0, rd);
        chk("datio_read", rd, 16'o000111);
        bus_phase(1'b1, 1'b0, 16'o000222, rd);
        bus_end();
        bus_read(16'o177706, rd);
        chk("datio_write", rd, 16'o000222);

        // Strobe aborts during WAITS
        bus_start(16'o177704, 1'b1);
        din = 1'b1;
        tick(); tick();
        din = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (rply) seen++;
        end
        chk("abort_rd_rply", 16'(seen), 16'd0);
        dbo  = 16'o000000;
        dout = 1'b1;
        tick(); tick();
        dout = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (rply) seen++;
        end
        chk("abort_wr_rply", 16'(seen), 16'd0);
        bus_end();
        bus_read(16'o177704, rd);
        chk("abort_no_write", rd, 16'o123456);

        // Clock enable freeze in WAITS and REPLY
        bus_start(16'o177710, 1'b1);
        dbo  = 16'o000555;
        dout = 1'b1;
        tick();
        ce = 1'b0;
        repeat (6) tick();
        chk("ce_wait_frozen", {15'd0, rply}, 16'd0);
        ce = 1'b1;
        tick(); tick();
        chk("ce_rply_early", {15'd0, rply}, 16'd0);
        tick();
        chk("ce_rply_on", {15'd0, rply}, 16'd1);
        ce   = 1'b0;
        dout = 1'b0;
        repeat (3) tick();
        chk("ce_reply_frozen", {15'd0, rply}, 16'd1);
        ce = 1'b1;
        tick();
        chk("ce_rply_off", {15'd0, rply}, 16'd0);
        bus_end();
        bus_read(16'o177710, rd);
        chk("ce_write", rd, 16'o000555);

`ifdef BUS_RESPONDER_ACCESS_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) bus_write(16'o177706, 1'b0, 16'o000007);
        bus_read(16'o177700, rd);
        chk("cnt_three", rd, 16'o000003);
        bus_read(16'o177700, rd);
        chk("cnt_four", rd, 16'o000004);
        bus_write(16'o177700, 1'b0, 16'o123456);
        bus_read(16'o177700, rd);
        chk("cnt_clear", rd, 16'o000000);
        force dut.r_acc_cnt = 16'hFFFF;
        tick();
        release dut.r_acc_cnt;
        bus_read(16'o177700, rd);
        chk("cnt_max", rd, 16'o177777);
        bus_read(16'o177700, rd);
        chk("cnt_wrap", rd, 16'o000000);
`else
        bus_write(16'o177700, 1'b0, 16'o011064);
        bus_read(16'o177700, rd);
        chk("word0_rw", rd, 16'o011064);
`endif

        // Reset in the middle of a reply
        bus_start(16'o177704, 1'b1);
        din = 1'b1;
        tick();
        repeat (c_WAIT) tick();
        tick();
        chk("mid_rply_on", {15'd0, rply}, 16'd1);
        chk("mid_dbi", dbi, 16'o123456);
        reset = 1'b1;
        tick();
        chk("rst_rply", {15'd0, rply}, 16'd0);
        chk("rst_dbi", dbi, 16'd0);
        chk("rst_hit", {15'd0, hit}, 16'd0);
        reset = 1'b0;
        din   = 1'b0;
        sync  = 1'b0;
        tick();
        bus_read(16'o177702, rd);
        chk("rst_reg1", rd, 16'd0);
        bus_read(16'o177704, rd);
        chk("rst_reg2", rd, 16'd0);
        bus_read(16'o177706, rd);
        chk("rst_reg3", rd, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
